// File: rtl/alu_pkg.sv
// Shared ALU constants: default datapath width and the register reset value.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MAX_W  = 64;

  // Reset value for every result register; slice to the block's width.
  localparam logic [MAX_W-1:0] RST_VAL = '0;

endpackage : alu_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder: one link of the ripple-carry chain.
//   a, b : operand bits
//   ci   : carry in from the next less significant bit
//   s    : sum bit
//   co   : carry out to the next more significant bit
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_c;

  assign p_c = a ^ b;
  assign s   = p_c ^ ci;
  assign co  = (a & b) | (ci & p_c);

endmodule : full_adder_cell

// File: rtl/rc_adder_32.sv
// Registered ripple-carry adder for the ALU datapath.
// Computes x + y + cin through a chain of full_adder_cell instances and
// registers the sum, the per-bit carry vector, carry-out and signed overflow.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset (clears all outputs)
//   x, y      : operands, WIDTH bits
//   cin       : carry into bit 0
//   in_valid  : operands valid this cycle; results update only when set
//   sum       : registered (x + y + cin) mod 2^WIDTH
//   carry     : registered per-bit carry-out vector
//   cout      : registered carry out of the MSB
//   ovf       : registered signed overflow
//   out_valid : registered copy of in_valid
module rc_adder_32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);

  logic [WIDTH-1:0] s_c;
  logic [WIDTH-1:0] c_c;

  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             out_valid_q;

  // Explicit ripple chain; bit 0 takes cin, every other bit the previous carry.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chain
    logic ci_c;
    if (i == 0) begin : g_lsb
      assign ci_c = cin;
    end else begin : g_bit
      assign ci_c = c_c[i-1];
    end
    full_adder_cell u_fa (
      .a  (x[i]),
      .b  (y[i]),
      .ci (ci_c),
      .s  (s_c[i]),
      .co (c_c[i])
    );
  end

  // Next-state: capture on valid, otherwise hold (inputs are ignored entirely).
  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (in_valid) begin
      sum_d   = s_c;
      carry_d = c_c;
      cout_d  = c_c[WIDTH-1];
      ovf_d   = c_c[WIDTH-1] ^ c_c[WIDTH-2];
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q       <= RST_VAL[WIDTH-1:0];
      carry_q     <= RST_VAL[WIDTH-1:0];
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      out_valid_q <= in_valid;
    end
  end

  assign sum       = sum_q;
  assign carry     = carry_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule : rc_adder_32

// File: tb/tb_rc_adder_32.sv
// Self-checking bench for rc_adder_32 at the default 8-bit width.
module tb_rc_adder_32;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] x, y;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] sum, carry;
  logic         cout, ovf, out_valid;

  // Reference state: what the outputs should show now.
  logic [W-1:0] m_sum, m_carry;
  logic         m_cout, m_ovf, m_valid;

  int n_cmp;
  int n_bad;

  rc_adder_32 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .cout      (cout),
    .ovf       (ovf),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: carry into bit i+1 is whether the low i+1 bits overflow;
  // signed overflow is the true signed result leaving the representable range.
  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                               output logic [W-1:0] s, output logic [W-1:0] c,
                               output logic co, output logic ov);
    int unsigned total;
    int unsigned m;
    int          st;
    total = int'(a) + int'(b) + int'(ci);
    for (int i = 0; i < int'(W); i++) begin
      m    = 32'd1 << (i + 1);
      c[i] = ((int'(a) % m) + (int'(b) % m) + int'(ci)) >= m;
    end
    s  = W'(total);
    co = total >= (32'd1 << W);
    st = int'($signed(a)) + int'($signed(b)) + int'(ci);
    ov = (st > ((1 << (W - 1)) - 1)) || (st < -(1 << (W - 1)));
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".sum"},       64'(sum),       64'(m_sum));
    chk({tag, ".carry"},     64'(carry),     64'(m_carry));
    chk({tag, ".cout"},      64'(cout),      64'(m_cout));
    chk({tag, ".ovf"},       64'(ovf),       64'(m_ovf));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
  endtask

  // Advance one edge with the currently driven inputs, update the model, compare.
  task automatic cycle_check(input string tag);
    logic [W-1:0] s, c;
    logic         co, ov;
    @(posedge clk);
    #1;
    if (reset) begin
      m_sum = '0; m_carry = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        calc(x, y, cin, s, c, co, ov);
        m_sum = s; m_carry = c; m_cout = co; m_ovf = ov;
      end
    end
    check_all(tag);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic v);
    x = a; y = b; cin = ci; in_valid = v;
  endtask

  // Directed vector with hand-derived expected values on top of the model check.
  task automatic plan_vec(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic [W-1:0] es, input logic [W-1:0] ec,
                          input logic eco, input logic eov);
    drive(a, b, ci, 1'b1);
    cycle_check(tag);
    chk({tag, ".const_sum"},   64'(sum),   64'(es));
    chk({tag, ".const_carry"}, 64'(carry), 64'(ec));
    chk({tag, ".const_cout"},  64'(cout),  64'(eco));
    chk({tag, ".const_ovf"},   64'(ovf),   64'(eov));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_sum = '0; m_carry = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    #2;
    check_all("reset_init");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    plan_vec("vec_2a_3a", 8'h2A, 8'h3A, 1'b0, 8'h64, 8'h3A, 1'b0, 1'b0);
    plan_vec("vec_69_15", 8'h69, 8'h15, 1'b0, 8'h7E, 8'h01, 1'b0, 1'b0);
    plan_vec("vec_ripple", 8'hFF, 8'h01, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0);
    plan_vec("vec_ovf_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1);
    plan_vec("vec_neg_ovf", 8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1);
    plan_vec("vec_all_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Back-to-back then idle: results one cycle after inputs, held while idle.
    drive(8'h12, 8'h34, 1'b0, 1'b1);
    cycle_check("b2b_a");
    drive(8'hC8, 8'h64, 1'b1, 1'b1);
    cycle_check("b2b_b");
    drive(W'($urandom), W'($urandom), 1'b1, 1'b0);
    cycle_check("b2b_idle");
    chk("b2b_idle.const_valid", 64'(out_valid), 64'(0));
    chk("b2b_idle.const_sum", 64'(sum), 64'(8'h2D));
    x = 'x; y = 'x; cin = 1'bx;
    cycle_check("idle_x");
    cycle_check("idle_x2");

    // Asynchronous reset mid-cycle with a valid result registered.
    drive(8'h55, 8'h22, 1'b0, 1'b1);
    cycle_check("pre_reset");
    #3;
    reset = 1'b1;
    #1;
    m_sum = '0; m_carry = '0; m_cout = 1'b0; m_ovf = 1'b0; m_valid = 1'b0;
    check_all("reset_async");
    cycle_check("reset_hold");
    drive(8'h0F, 8'h01, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    cycle_check("post_reset_idle");
    drive(8'h0F, 8'h01, 1'b0, 1'b1);
    cycle_check("post_reset_first");

    // Randomized traffic with random gaps.
    for (int i = 0; i < 300; i++) begin
      drive(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      if (!in_valid && ($urandom_range(0, 1) == 1)) begin
        x = 'x; y = 'x;
      end
      cycle_check("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_rc_adder_32
